// File: rtl/fetch_stage.sv
// Instruction fetch stage: one non-abortable memory request at a time, IF/ID register plus a one-entry skid for stalls.
// Optional FETCH_PREDECODE_JUMP_EN: JMP/JAL words steer the next fetch address directly.
module fetch_stage (
  input  logic        clk,
  input  logic        reset_n,
  output logic        i_readM,
  output logic [15:0] i_address,
  input  logic [15:0] i_data,
  input  logic        i_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        ifid_valid,
  output logic [15:0] ifid_inst,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc_next,
  output logic [1:0]  fetch_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] redir_pc;
  logic [15:0] skid_inst;
  logic [15:0] skid_pc;
  logic        req;
  logic        drop;
  logic        halt_pend;
  logic        halt_now;
  logic [15:0] pc_inc;
  logic [15:0] next_pc;

  assign halt_now    = halt | halt_pend;
  assign pc_inc      = pc + 16'd1;
  assign i_readM     = reset_n & req;
  assign i_address   = pc;
  assign fetch_state = state;

  always_comb begin
    next_pc = pc_inc;
`ifdef FETCH_PREDECODE_JUMP_EN
    if (i_data[15:12] == 4'd9 || i_data[15:12] == 4'd10)
      next_pc = {pc[15:12], i_data[11:0]};
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_FETCH;
      pc           <= 16'h0000;
      redir_pc     <= 16'h0000;
      skid_inst    <= 16'h0000;
      skid_pc      <= 16'h0000;
      req          <= 1'b0;
      drop         <= 1'b0;
      halt_pend    <= 1'b0;
      ifid_valid   <= 1'b0;
      ifid_inst    <= 16'h0000;
      ifid_pc      <= 16'h0000;
      ifid_pc_next <= 16'h0000;
    end else if (redirect_valid && state != S_HALT) begin
      // pc must stay put while a request is in flight, so park the target until it completes
      ifid_valid <= 1'b0;
      skid_inst  <= 16'h0000;
      skid_pc    <= 16'h0000;
      state      <= S_FETCH;
      halt_pend  <= 1'b0;
      if (req && !i_ready) begin
        drop     <= 1'b1;
        redir_pc <= redirect_pc;
      end else begin
        drop <= 1'b0;
        pc   <= redirect_pc;
        req  <= 1'b1;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (!req) begin
            if (halt_now) begin
              state      <= S_HALT;
              ifid_valid <= 1'b0;
              halt_pend  <= 1'b0;
            end else begin
              req <= 1'b1;
            end
          end else if (i_ready) begin
            drop <= 1'b0;
            if (halt_now) begin
              state      <= S_HALT;
              req        <= 1'b0;
              ifid_valid <= 1'b0;
              halt_pend  <= 1'b0;
            end else if (drop) begin
              pc <= redir_pc;
              if (!stall) ifid_valid <= 1'b0;
            end else if (!ifid_valid || !stall) begin
              ifid_valid   <= 1'b1;
              ifid_inst    <= i_data;
              ifid_pc      <= pc;
              ifid_pc_next <= pc_inc;
              pc           <= next_pc;
            end else begin
              skid_inst <= i_data;
              skid_pc   <= pc;
              pc        <= next_pc;
              req       <= 1'b0;
              state     <= S_HOLD;
            end
          end else begin
            if (halt) halt_pend <= 1'b1;
            if (!stall) ifid_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (halt_now) begin
            state      <= S_HALT;
            ifid_valid <= 1'b0;
            halt_pend  <= 1'b0;
          end else if (!stall) begin
            ifid_valid   <= 1'b1;
            ifid_inst    <= skid_inst;
            ifid_pc      <= skid_pc;
            ifid_pc_next <= skid_pc + 16'd1;
            state        <= S_FETCH;
            req          <= 1'b1;
          end
        end
        S_HALT: begin
          req        <= 1'b0;
          ifid_valid <= 1'b0;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: the bench plays instruction memory; accepted words are queued and checked as they reach IF/ID.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_ready;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        ifid_valid;
  logic [15:0] ifid_inst;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_next;
  logic [1:0]  fetch_state;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
    logic [15:0] pcn;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n),
    .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .ifid_valid(ifid_valid), .ifid_inst(ifid_inst), .ifid_pc(ifid_pc),
    .ifid_pc_next(ifid_pc_next), .fetch_state(fetch_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // memory answers the outstanding request after two cycles
  task automatic serve(input logic [15:0] word);
    step();
    i_ready = 1'b1;
    i_data  = word;
    step();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_ready = 1'b1; i_data = 16'hAAAA; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
    #1;
    total++;
    if (i_readM !== 1'b0) begin bad++; $display("FAIL reset_readM_async got=%b want=0", i_readM); end
    step(); step();
    total++;
    if ({i_readM, ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, fetch_state} !== {1'b0, 1'b0, 48'h0, 2'd0}) begin
      bad++;
      $display("FAIL reset_state got rd=%b v=%b inst=%h pc=%h pcn=%h st=%0d want all zero",
               i_readM, ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, fetch_state);
    end
    reset_n = 1'b1;
    step();
    i_ready = 1'b0;
    total++;
    if ({i_readM, i_address, ifid_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL reset_release got rd=%b addr=%h v=%b want rd=1 addr=0000 v=0", i_readM, i_address, ifid_valid);
    end
  endtask

  task automatic test_sequence();
    logic [15:0] words[5];
    words[0] = 16'hF01C; words[1] = 16'h6000; words[2] = 16'h1002; words[3] = 16'h1003; words[4] = 16'h1004;
    for (int a = 0; a < 5; a++) begin
      exp_q.push_back('{inst: words[a], pc: 16'(a), pcn: 16'(a + 1)});
      serve(words[a]);
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL seq_queue_empty a=%0d", a); end
      else begin
        e = exp_q.pop_front();
        if ({ifid_valid, ifid_inst, ifid_pc, ifid_pc_next} !== {1'b1, e.inst, e.pc, e.pcn}) begin
          bad++;
          $display("FAIL seq_ifid a=%0d got v=%b inst=%h pc=%h pcn=%h want v=1 inst=%h pc=%h pcn=%h",
                   a, ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, e.inst, e.pc, e.pcn);
        end
      end
      total++;
      if ({i_readM, i_address} !== {1'b1, 16'(a + 1)}) begin
        bad++;
        $display("FAIL seq_next_addr a=%0d got rd=%b addr=%h want rd=1 addr=%h", a, i_readM, i_address, 16'(a + 1));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    step();
    i_ready = 1'b1; i_data = 16'h5555;
    exp_q.push_back('{inst: 16'h5555, pc: 16'h0005, pcn: 16'h0006});
    step();
    i_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if ({fetch_state, i_readM, ifid_valid, ifid_pc} !== {2'd1, 1'b0, 1'b1, 16'h0004}) begin
        bad++;
        $display("FAIL stall_hold c=%0d got st=%0d rd=%b v=%b pc=%h want st=1 rd=0 v=1 pc=0004",
                 c, fetch_state, i_readM, ifid_valid, ifid_pc);
      end
      step();
    end
    stall = 1'b0;
    step();
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL stall_queue_empty"); end
    else begin
      e = exp_q.pop_front();
      if ({fetch_state, ifid_valid, ifid_inst, ifid_pc, ifid_pc_next} !== {2'd0, 1'b1, e.inst, e.pc, e.pcn}) begin
        bad++;
        $display("FAIL stall_release got st=%0d v=%b inst=%h pc=%h pcn=%h want st=0 v=1 inst=%h pc=%h pcn=%h",
                 fetch_state, ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, e.inst, e.pc, e.pcn);
      end
    end
    total++;
    if ({i_readM, i_address} !== {1'b1, 16'h0006}) begin
      bad++; $display("FAIL stall_resume got rd=%b addr=%h want rd=1 addr=0006", i_readM, i_address);
    end
  endtask

  task automatic test_redirect_outstanding();
    exp_q.push_back('{inst: 16'h6666, pc: 16'h0006, pcn: 16'h0007});
    serve(16'h6666);
    total++;
    e = exp_q.pop_front();
    if ({ifid_inst, ifid_pc} !== {e.inst, e.pc}) begin
      bad++; $display("FAIL redir_pre got inst=%h pc=%h want inst=%h pc=%h", ifid_inst, ifid_pc, e.inst, e.pc);
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect_valid = 1'b0;
    total++;
    if ({i_readM, i_address, ifid_valid} !== {1'b1, 16'h0007, 1'b0}) begin
      bad++; $display("FAIL redir_hold got rd=%b addr=%h v=%b want rd=1 addr=0007 v=0", i_readM, i_address, ifid_valid);
    end
    serve(16'hDEAD);
    total++;
    if ({i_readM, i_address, ifid_valid} !== {1'b1, 16'h0040, 1'b0}) begin
      bad++; $display("FAIL redir_drop got rd=%b addr=%h v=%b want rd=1 addr=0040 v=0", i_readM, i_address, ifid_valid);
    end
  endtask

  task automatic test_redirect_same_cycle();
    step();
    i_ready = 1'b1; i_data = 16'hBEEF; redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step();
    i_ready = 1'b0; redirect_valid = 1'b0;
    total++;
    if ({i_readM, i_address, ifid_valid} !== {1'b1, 16'h0100, 1'b0}) begin
      bad++; $display("FAIL redir_same got rd=%b addr=%h v=%b want rd=1 addr=0100 v=0", i_readM, i_address, ifid_valid);
    end
  endtask

  task automatic test_wrap();
    i_ready = 1'b1; i_data = 16'h0BAD; redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    step();
    i_ready = 1'b0; redirect_valid = 1'b0;
    exp_q.push_back('{inst: 16'h7777, pc: 16'hFFFF, pcn: 16'h0000});
    serve(16'h7777);
    total++;
    e = exp_q.pop_front();
    if ({ifid_valid, ifid_inst, ifid_pc, ifid_pc_next} !== {1'b1, e.inst, e.pc, e.pcn}) begin
      bad++;
      $display("FAIL wrap_ifid got v=%b inst=%h pc=%h pcn=%h want v=1 inst=%h pc=%h pcn=%h",
               ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, e.inst, e.pc, e.pcn);
    end
    total++;
    if (i_address !== 16'h0000) begin bad++; $display("FAIL wrap_addr got=%h want=0000", i_address); end
  endtask

  task automatic test_predecode();
    logic [15:0] want;
`ifdef FETCH_PREDECODE_JUMP_EN
    want = 16'h5123;
`else
    want = 16'h5011;
`endif
    i_ready = 1'b1; i_data = 16'h0BAD; redirect_valid = 1'b1; redirect_pc = 16'h5010;
    step();
    i_ready = 1'b0; redirect_valid = 1'b0;
    total++;
    if (i_address !== 16'h5010) begin bad++; $display("FAIL jmp_setup got=%h want=5010", i_address); end
    exp_q.push_back('{inst: 16'h9123, pc: 16'h5010, pcn: 16'h5011});
    serve(16'h9123);
    total++;
    e = exp_q.pop_front();
    if ({ifid_inst, ifid_pc, ifid_pc_next, i_address} !== {e.inst, e.pc, e.pcn, want}) begin
      bad++;
      $display("FAIL jmp_next got inst=%h pc=%h pcn=%h addr=%h want inst=%h pc=%h pcn=%h addr=%h",
               ifid_inst, ifid_pc, ifid_pc_next, i_address, e.inst, e.pc, e.pcn, want);
    end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    step();
    halt = 1'b0;
    total++;
    if ({fetch_state, i_readM} !== {2'd0, 1'b1}) begin
      bad++; $display("FAIL halt_wait got st=%0d rd=%b want st=0 rd=1", fetch_state, i_readM);
    end
    serve(16'h1234);
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({fetch_state, i_readM, ifid_valid} !== {2'd2, 1'b0, 1'b0}) begin
        bad++; $display("FAIL halt_state c=%0d got st=%0d rd=%b v=%b want st=2 rd=0 v=0", c, fetch_state, i_readM, ifid_valid);
      end
      i_ready = 1'b1; i_data = 16'h4321;
      step();
      i_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_wrap();
    test_predecode();
    test_halt();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL queue_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have: i_readM  out  1  instruction-memory read request.
REQ-004 SHALL have: i_address  out  16  word address of request.
REQ-005 SHALL have: i_data  in  16  instruction word, valid when i_ready=1.
REQ-006 SHALL have: i_ready  in  1  memory completion strobe, one cycle per request.
REQ-007 SHALL have: stall  in  1  hazard unit holds IF/ID register.
REQ-008 SHALL have: redirect_valid  in  1  taken branch or JPR/JRL resolved downstream.
REQ-009 SHALL have: redirect_pc  in  16  new fetch address.
REQ-010 SHALL have: halt  in  1  HLT decoded in ID.
REQ-011 SHALL have: ifid_valid  out  1, ifid_inst  out  16, ifid_pc  out  16, ifid_pc_next  out  16 (PC+1 for JAL/JRL link); all registered.
REQ-012 SHALL have: fetch_state  out  2  current FSM state, for debug.

Function
REQ-013 FSM states SHALL be S_FETCH=0, S_HOLD=1, S_HALT=2.
REQ-014 In S_FETCH, i_readM SHALL be 1 and i_address SHALL equal the request's PC, held constant until i_ready.
REQ-015 Each request SHALL be non-abortable; pc SHALL NOT change while a request is outstanding.
REQ-016 On i_ready with no discard, IF/ID free (ifid_valid=0 or stall=0): load ifid_inst=i_data, ifid_pc=pc, ifid_pc_next=pc+1, ifid_valid=1; pc<=pc+1 (16-bit wrap, FFFF->0000); stay S_FETCH.
REQ-017 On i_ready with no discard, stall=1, ifid_valid=1: capture word into skid register; enter S_HOLD; i_readM=0.
REQ-018 In S_HOLD, when stall=0: skid SHALL move to IF/ID with ifid_valid=1 and return to S_FETCH next cycle.
REQ-019 stall=1 with no i_ready SHALL leave IF/ID contents unchanged.
REQ-020 redirect_valid=1 SHALL take priority over stall and i_ready: ifid_valid<=0, skid cleared, pc<=redirect_pc, enter S_FETCH.
REQ-021 Redirect while request outstanding and i_ready=0 SHALL set drop flag; next i_ready SHALL be discarded, then redirect_pc requested.
REQ-022 Redirect coincident with i_ready SHALL discard data, no drop flag; redirect_pc requested next cycle.
REQ-023 halt=1 (redirect_valid=0) SHALL enter S_HALT after any outstanding request completes (that data discarded); S_HALT SHALL keep i_readM=0 and ifid_valid=0 until reset.
REQ-024 Request launch latency SHALL be 1 cycle after reset release or after a completed/discarded fetch when IF/ID is free.

Reset
REQ-025 When reset_n=0 at clk edge: pc=16'h0000, state=S_FETCH, drop flag=0, skid empty, ifid_valid=0, ifid_inst=16'h0000, ifid_pc=0, ifid_pc_next=0.
REQ-026 i_readM SHALL be 0 while reset_n=0; reset mid-request SHALL abandon it, and any i_ready in the first cycle after release SHALL be ignored.

Configuration
REQ-027 Macro FETCH_PREDECODE_JUMP_EN defined: on accepting a word with opcode 4'd9 (JMP) or 4'd10 (JAL), pc SHALL become {pc[15:12], i_data[11:0]} instead of pc+1; IF/ID load unchanged.
REQ-028 Macro undefined: pc SHALL always advance to pc+1; jumps resolve only via redirect_valid.

Verification
REQ-029 Reset, i_ready 2 cycles after each request, words 16'hF01C,16'h6000 -> i_address 0,1,2; ifid_pc 0 then 1; ifid_pc_next 1 then 2.
REQ-030 stall=1 held 3 cycles while word at addr 5 returns -> S_HOLD, i_readM=0; after release ifid_inst=word5, ifid_pc=5, fetch resumes at 6.
REQ-031 redirect_valid=1, redirect_pc=16'h0040 while addr 7 outstanding -> data at 7 discarded, next i_address=16'h0040, ifid_valid=0 in between.
REQ-032 redirect and i_ready same cycle -> no IF/ID load, i_address=redirect_pc next cycle.
REQ-033 pc=16'hFFFF accepted -> next i_address=16'h0000, ifid_pc_next=16'h0000.
REQ-034 With FETCH_PREDECODE_JUMP_EN, word 16'h9123 at pc 16'h5010 -> next i_address 16'h5123; without macro -> 16'h5011.
